// File: rtl/mario_key_pkg.sv
// Shared HID keycode constants and jump FSM state type for the Mario keyboard front end.
package mario_key_pkg;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  localparam int unsigned EVT_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RISE     = 2'd1,
    WAIT_REL = 2'd2
  } jump_state_t;

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through event FIFO; dout keeps the last popped word while empty.
module key_evt_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign dout  = empty ? last_q : mem[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a push into a full FIFO is legal then.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = mem[rd_ptr_q];
    end
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/keycode_action_ctrl.sv
// Debounces the SoC HID keycode, decodes movement keys and runs the frame-timed jump FSM.
// Define KEY_EVENT_FIFO_EN to queue {old,new} key-change events; otherwise the event ports are tied off.
module keycode_action_ctrl
  import mario_key_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES   = 4,
  parameter int unsigned JUMP_MAX_FRAMES = 16,
  parameter logic [7:0]  KEY_LEFT        = KEY_A,
  parameter logic [7:0]  KEY_RIGHT       = KEY_D,
  parameter logic [7:0]  KEY_JUMP        = KEY_W,
  parameter logic [7:0]  KEY_RUN         = KEY_S,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [7:0]       keycode,
  input  logic             frame_tick,
  output logic [7:0]       key_stable,
  output logic             move_left,
  output logic             move_right,
  output logic             run,
  output logic             jump_start,
  output logic             jump_hold,
  output logic             evt_valid,
  output logic [EVT_W-1:0] evt_data,
  input  logic             evt_ready,
  output logic             evt_overflow
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned FC_W  = $clog2(JUMP_MAX_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [FC_W-1:0]  FC_MAX  = FC_W'(JUMP_MAX_FRAMES);

  logic [7:0]       cand_q, cand_d, key_stable_q, key_stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             move_left_q, move_left_d, move_right_q, move_right_d, run_q, run_d;
  jump_state_t      state_q, state_d;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic             jump_start_q, jump_start_d, jump_hold_q, jump_hold_d;

  // Accept on the edge where the count reaches the threshold, so the key lands on edge N.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (keycode != cand_q) begin
      cand_d = keycode;
      cnt_d  = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    accept       = (cnt_d == CNT_MAX) && (cand_d != key_stable_q);
    key_stable_d = accept ? cand_d : key_stable_q;
    move_left_d  = (key_stable_q == KEY_LEFT);
    move_right_d = (key_stable_q == KEY_RIGHT);
    run_d        = (key_stable_q == KEY_RUN);
  end

  // Release is checked before the frame tick so a release always wins.
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    jump_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && (cand_d == KEY_JUMP)) begin
          state_d      = RISE;
          jump_start_d = 1'b1;
          frame_cnt_d  = '0;
        end
      end
      RISE: begin
        if (key_stable_q != KEY_JUMP) begin
          state_d = IDLE;
        end else if (frame_tick) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          if (frame_cnt_d == FC_MAX) state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (key_stable_q != KEY_JUMP) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    jump_hold_d = (state_d == RISE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cand_q       <= KEY_NONE;
      cnt_q        <= '0;
      key_stable_q <= KEY_NONE;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      run_q        <= 1'b0;
      state_q      <= IDLE;
      frame_cnt_q  <= '0;
      jump_start_q <= 1'b0;
      jump_hold_q  <= 1'b0;
    end else begin
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      key_stable_q <= key_stable_d;
      move_left_q  <= move_left_d;
      move_right_q <= move_right_d;
      run_q        <= run_d;
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      jump_start_q <= jump_start_d;
      jump_hold_q  <= jump_hold_d;
    end
  end

  assign key_stable = key_stable_q;
  assign move_left  = move_left_q;
  assign move_right = move_right_q;
  assign run        = run_q;
  assign jump_start = jump_start_q;
  assign jump_hold  = jump_hold_q;

`ifdef KEY_EVENT_FIFO_EN
  logic fifo_full, fifo_empty;
  logic evt_overflow_q, evt_overflow_d;

  key_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk   (Clk),
    .rst   (Reset),
    .push  (accept),
    .din   ({key_stable_q, cand_d}),
    .pop   (evt_ready),
    .dout  (evt_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    evt_overflow_d = evt_overflow_q;
    if (accept && fifo_full && !evt_ready) evt_overflow_d = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) evt_overflow_q <= 1'b0;
    else       evt_overflow_q <= evt_overflow_d;
  end

  assign evt_valid    = !fifo_empty;
  assign evt_overflow = evt_overflow_q;
`else
  localparam int unsigned unused_fifo_depth = FIFO_DEPTH;
  logic unused_evt_ready;
  assign unused_evt_ready = evt_ready;
  assign evt_valid        = 1'b0;
  assign evt_data         = '0;
  assign evt_overflow     = 1'b0;
`endif

endmodule
